// File: rtl/fp_addsub_arbiter_if.sv
// fp_addsub_arbiter_if: requester-side and unit-side signals of the shared FP add/sub arbiter
interface fp_addsub_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_mode;
    logic [32*NREQ-1:0]   req_op1;
    logic [32*NREQ-1:0]   req_op2;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_result;
    logic                 rsp_overflow;
    logic                 rsp_error;
    logic                 busy;
    logic                 fu_start;
    logic                 fu_mode;
    logic [31:0]          fu_op1;
    logic [31:0]          fu_op2;
    logic [31:0]          fu_result;
    logic                 fu_done;
    logic                 fu_overflow;
    modport slave (
        input  req, req_mode, req_op1, req_op2, fu_result, fu_done, fu_overflow,
        output gnt, rsp_valid, rsp_result, rsp_overflow, rsp_error, busy,
               fu_start, fu_mode, fu_op1, fu_op2
    );
    modport master (
        output req, req_mode, req_op1, req_op2, fu_result, fu_done, fu_overflow,
        input  gnt, rsp_valid, rsp_result, rsp_overflow, rsp_error, busy,
               fu_start, fu_mode, fu_op1, fu_op2
    );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: round-robin sharing of one FP add/sub unit; FP_ARB_TIMEOUT_EN adds a WAIT watchdog
module fp_addsub_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    fp_addsub_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t        r_state, w_next;
    logic [IW-1:0] r_ptr, r_owner, w_winner;
    logic          w_found, w_timeout, w_capture;
    logic          r_mode, r_ovf;
    logic [31:0]   r_op1, r_op2, r_result;
    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("fp_addsub_arbiter: illegal parameter values");
    end
    // Scan from farthest to nearest so the first set bit after ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[IW'((int'(r_ptr) + k) % NREQ)]) begin
                w_found  = 1'b1;
                w_winner = IW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end
    assign w_capture = (r_state == WAIT) && (bus.fu_done || w_timeout);
    always_comb begin
        w_next = (r_state == IDLE)  ? (w_found ? ISSUE : IDLE) :
                 (r_state == ISSUE) ? WAIT :
                 (r_state == WAIT)  ? (w_capture ? RESP : WAIT) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= IW'(NREQ - 1);
            r_owner  <= '0;
            r_mode   <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_found) begin
                r_owner <= w_winner;
                r_mode  <= bus.req_mode[w_winner];
                r_op1   <= bus.req_op1[32*int'(w_winner) +: 32];
                r_op2   <= bus.req_op2[32*int'(w_winner) +: 32];
            end
            if (w_capture) begin
                r_result <= bus.fu_done ? bus.fu_result : 32'h7FC0_0000;
                r_ovf    <= bus.fu_done & bus.fu_overflow;
            end
            if (r_state == RESP) r_ptr <= r_owner;
        end
    end
`ifdef FP_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_cnt;
    logic          r_err;
    assign w_timeout = (r_cnt == TW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == WAIT) ? r_cnt + TW'(1) : '0;
            if (w_capture) r_err <= ~bus.fu_done;
        end
    end
    assign bus.rsp_error = r_err;
`else
    assign w_timeout     = 1'b0;
    assign bus.rsp_error = 1'b0;
`endif
    assign bus.gnt          = (r_state == IDLE && w_found && !rst) ? NREQ'(1) << w_winner : '0;
    assign bus.rsp_valid    = (r_state == RESP && !rst) ? NREQ'(1) << r_owner : '0;
    assign bus.fu_start     = (r_state == ISSUE) && !rst;
    assign bus.busy         = (r_state != IDLE);
    assign bus.fu_mode      = r_mode;
    assign bus.fu_op1       = r_op1;
    assign bus.fu_op2       = r_op2;
    assign bus.rsp_result   = r_result;
    assign bus.rsp_overflow = r_ovf;
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb_fp_addsub_arbiter: directed + randomized checks of the arbiter against a round-robin reference model
module tb_fp_addsub_arbiter;
    logic clk, rst;
    int   n_vec, n_err;
    int   ref_ptr;
    int   stub_lat, pend;
    bit   glitch;
    logic [31:0] stub_res;
    logic        stub_ovf;
    logic        mode [4];
    logic [31:0] op1 [4];
    logic [31:0] op2 [4];

    fp_addsub_arbiter_if #(.NREQ(4)) bus ();
    fp_addsub_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub unit: done pulses stub_lat cycles after the start it sees; 0 means never.
    always @(negedge clk) if (bus.fu_start === 1'b1) pend = stub_lat;
    always @(posedge clk) begin
        #1;
        if (pend == 1) begin
            bus.fu_done     = 1'b1;
            bus.fu_result   = stub_res;
            bus.fu_overflow = stub_ovf;
        end else begin
            bus.fu_done     = 1'b0;
            bus.fu_result   = $urandom;
            bus.fu_overflow = 1'($urandom);
        end
        if (pend > 0) pend--;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_pick(input logic [3:0] rv);
        for (int k = 1; k <= 4; k++) if (rv[(ref_ptr + k) % 4]) return (ref_ptr + k) % 4;
        return -1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < 4; i++) begin
            mode[i] = 1'($urandom);
            op1[i]  = $urandom;
            op2[i]  = $urandom;
        end
        stub_res = $urandom;
        stub_ovf = 1'($urandom);
    endtask

    task automatic drive_req(input logic [3:0] rv);
        bus.req = rv;
        for (int i = 0; i < 4; i++) begin
            bus.req_mode[i]         = mode[i];
            bus.req_op1[32*i +: 32] = op1[i];
            bus.req_op2[32*i +: 32] = op2[i];
        end
    endtask

    // Called just after a clock edge with the DUT in IDLE; returns at the response cycle.
    task automatic run_op(input logic [3:0] rv, input int lat, input bit keep);
        int w, n;
        w = ref_pick(rv);
        drive_req(rv);
        stub_lat = lat;
        @(negedge clk);
        chk("gnt", bus.gnt, 32'(1 << w));
        chk("busy_idle", bus.busy, 0);
        step();
        if (!keep) bus.req = '0;
        @(negedge clk);
        chk("fu_start", bus.fu_start, 1);
        chk("gnt_issue", bus.gnt, 0);
        chk("fu_mode", bus.fu_mode, mode[w]);
        chk("fu_op1", bus.fu_op1, op1[w]);
        chk("fu_op2", bus.fu_op2, op2[w]);
        if (glitch) begin
            #1;
            bus.fu_done   = 1'b1;
            bus.fu_result = 32'hDEAD_BEEF;
        end
        n = 1;
        do begin
            step();
            n++;
            @(negedge clk);
        end while (bus.rsp_valid == 0 && n < 60);
        chk("rsp_latency", n, 2 + lat);
        chk("rsp_valid", bus.rsp_valid, 32'(1 << w));
        chk("rsp_result", bus.rsp_result, stub_res);
        chk("rsp_overflow", bus.rsp_overflow, stub_ovf);
        chk("rsp_error", bus.rsp_error, 0);
        chk("fu_op1_hold", bus.fu_op1, op1[w]);
        ref_ptr = w;
    endtask

    initial begin
        int w, n, seen;
        n_vec = 0; n_err = 0; pend = 0; stub_lat = 1; glitch = 0;
        ref_ptr = 3;
        rand_ops();
        bus.req = '0; bus.req_mode = '0; bus.req_op1 = '0; bus.req_op2 = '0;
        bus.fu_done = 1'b0; bus.fu_result = '0; bus.fu_overflow = 1'b0;
        rst = 1'b1;
        bus.req = 4'hF;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_fu_start", bus.fu_start, 0);
            chk("rst_fu_op1", bus.fu_op1, 0);
            chk("rst_rsp_result", bus.rsp_result, 0);
            chk("rst_rsp_error", bus.rsp_error, 0);
            step();
        end
        rst = 1'b0;
        bus.req = '0;
        // Directed single add, L=1
        mode[0] = 1'b0; op1[0] = 32'h3FA0_0000; op2[0] = 32'h3FC0_0000;
        stub_res = 32'h4030_0000; stub_ovf = 1'b0;
        run_op(4'b0001, 1, 0);
        // Fairness with all requests held
        for (int i = 0; i < 5; i++) begin
            step();
            rand_ops();
            stub_ovf = 1'b0;
            run_op(4'hF, 1, 1);
        end
        step();
        bus.req = '0;
        // Overflow passthrough
        rand_ops();
        stub_ovf = 1'b1;
        run_op(4'b0100, 1, 0);
        // Done seen during ISSUE must be ignored
        step();
        rand_ops();
        glitch = 1;
        run_op(4'b1000, 3, 0);
        glitch = 0;
        // Randomized traffic
        for (int i = 0; i < 25; i++) begin
            step();
            rand_ops();
            run_op(4'($urandom_range(1, 15)), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end
        step();
        bus.req = '0;
        // Reset in WAIT
        step();
        rand_ops();
        drive_req(4'b0100);
        stub_lat = 5;
        @(negedge clk);
        chk("mid_gnt", bus.gnt, 32'h4);
        step();
        bus.req = '0;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rsp_valid", bus.rsp_valid, 0);
        step();
        rst = 1'b0;
        ref_ptr = 3;
        chk("mid_busy", bus.busy, 0);
        chk("mid_rsp_result", bus.rsp_result, 0);
        chk("mid_fu_op1", bus.fu_op1, 0);
        rand_ops();
        run_op(4'b0101, 1, 0);
        // Hung unit
        step();
        rand_ops();
        w = ref_pick(4'b0010);
        drive_req(4'b0010);
        stub_lat = 0;
        @(negedge clk);
        chk("to_gnt", bus.gnt, 32'(1 << w));
        step();
        bus.req = '0;
        n = 1;
`ifdef FP_ARB_TIMEOUT_EN
        do begin
            step();
            n++;
            @(negedge clk);
        end while (bus.rsp_valid == 0 && n < 100);
        chk("to_latency", n, 18);
        chk("to_rsp_valid", bus.rsp_valid, 32'(1 << w));
        chk("to_rsp_error", bus.rsp_error, 1);
        chk("to_rsp_result", bus.rsp_result, 32'h7FC0_0000);
        chk("to_rsp_overflow", bus.rsp_overflow, 0);
        ref_ptr = w;
        step();
`else
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            @(negedge clk);
            if (bus.rsp_valid != 0) seen++;
        end
        chk("hang_busy", bus.busy, 1);
        chk("hang_rsp_seen", seen, 0);
        chk("hang_rsp_error", bus.rsp_error, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ref_ptr = 3;
`endif
        rand_ops();
        run_op(4'hF, 2, 0);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
